// File: rtl/stage_queue_if.sv
// rtl/stage_queue_if.sv - handshake bundle between a pipeline stage queue and its neighbours
interface stage_queue_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
);
  logic                       flush;
  logic                       in_valid;
  logic                       in_allowin;
  logic [WIDTH-1:0]           in_data;
  logic                       out_valid;
  logic                       out_allowin;
  logic [WIDTH-1:0]           out_data;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       full;
  logic                       empty;

  modport master (
    output flush, in_valid, in_data, out_allowin,
    input  in_allowin, out_valid, out_data, count, full, empty
  );

  modport slave (
    input  flush, in_valid, in_data, out_allowin,
    output in_allowin, out_valid, out_data, count, full, empty
  );
endinterface

// File: rtl/stage_queue.sv
// rtl/stage_queue.sv - circular-buffer queue decoupling two pipeline stages
module stage_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  stage_queue_if.slave     q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;

  // allowin depends only on occupancy, so a pop never frees a slot in the same cycle
  assign q.full       = (cnt == CNT_FULL);
  assign q.empty      = (cnt == '0);
  assign q.count      = cnt;
  assign q.in_allowin = !q.full;
  assign q.out_valid  = !q.empty && !q.flush;
  assign q.out_data   = q.out_valid ? mem[rd_ptr] : '0;

  assign push = q.in_valid && q.in_allowin && !q.flush;
  assign pop  = q.out_valid && q.out_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= q.in_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      cnt <= cnt + CNT_ONE;
      else if (pop && !push) cnt <= cnt - CNT_ONE;
    end
  end
endmodule

// File: tb/tb_stage_queue.sv
// tb/tb_stage_queue.sv - randomized and directed checks of stage_queue against a queue model
`timescale 1ns/100ps
module tb_stage_queue;
  localparam int WIDTH = 64;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  stage_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) qi();

  stage_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (qi.slave)
  );

  always #5 clk = ~clk;

  // Reference: a plain FIFO of accepted payloads
  logic [WIDTH-1:0] mq[$];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
    end else if (qi.flush) begin
      mq.delete();
    end else begin
      automatic bit do_push = qi.in_valid && (mq.size() < DEPTH);
      automatic bit do_pop  = (mq.size() > 0) && qi.out_allowin;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(qi.in_data);
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    automatic bit       ev = (mq.size() > 0) && !qi.flush;
    automatic logic [WIDTH-1:0] ed = ev ? mq[0] : '0;
    chk("model_out_valid", qi.out_valid, ev);
    chk("model_out_data", qi.out_data, ed);
    chk("model_count", qi.count, mq.size());
    chk("model_full", qi.full, mq.size() == DEPTH);
    chk("model_empty", qi.empty, mq.size() == 0);
    chk("model_in_allowin", qi.in_allowin, mq.size() < DEPTH);
  end

  task automatic cyc(input bit v, input logic [WIDTH-1:0] d, input bit oa, input bit fl);
    @(negedge clk);
    #1;
    qi.in_valid    = v;
    qi.in_data     = d;
    qi.out_allowin = oa;
    qi.flush       = fl;
    #1;
  endtask

  initial begin
    qi.in_valid = 1'b0; qi.in_data = '0; qi.out_allowin = 1'b0; qi.flush = 1'b0;
    #1;
    chk("rst_out_valid", qi.out_valid, 0);
    chk("rst_count", qi.count, 0);
    chk("rst_empty", qi.empty, 1);
    chk("rst_in_allowin", qi.in_allowin, 1);
    chk("rst_out_data", qi.out_data, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Fill, then full with a simultaneous pop
    cyc(1, 64'h1, 0, 0);
    cyc(1, 64'h2, 0, 0);
    cyc(1, 64'h3, 0, 0);
    chk("fill_count", qi.count, 2);
    chk("fill_full", qi.full, 1);
    chk("fill_allowin", qi.in_allowin, 0);
    chk("fill_head", qi.out_data, 64'h1);
    cyc(1, 64'h3, 1, 0);
    chk("fullpop_count", qi.count, 2);
    chk("fullpop_head", qi.out_data, 64'h1);
    cyc(0, 0, 0, 0);
    chk("afterpop_count", qi.count, 1);
    chk("afterpop_head", qi.out_data, 64'h2);
    chk("afterpop_allowin", qi.in_allowin, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("drain_empty", qi.empty, 1);

    // Streaming at one entry per cycle
    for (int i = 0; i < 8; i++) begin
      cyc(1, 64'h10 + i, 1, 0);
      if (i > 0) begin
        chk("stream_data", qi.out_data, 64'h10 + i - 1);
        chk("stream_count", qi.count, 1);
      end
    end
    cyc(0, 0, 1, 0);
    chk("stream_last", qi.out_data, 64'h17);
    cyc(0, 0, 0, 0);
    chk("stream_empty", qi.empty, 1);

    // Flush with a push offered in the same cycle
    cyc(1, 64'hA1, 0, 0);
    cyc(1, 64'hA2, 0, 0);
    cyc(1, 64'hBB, 0, 1);
    chk("flush_count_pre", qi.count, 2);
    chk("flush_out_valid", qi.out_valid, 0);
    cyc(0, 0, 1, 0);
    chk("flush_count", qi.count, 0);
    chk("flush_empty", qi.empty, 1);
    chk("flush_no_output", qi.out_valid, 0);

    // Asynchronous reset between edges
    cyc(1, 64'hC1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("arst_pre_count", qi.count, 1);
    resetn = 1'b0;
    #1;
    chk("arst_count", qi.count, 0);
    chk("arst_out_valid", qi.out_valid, 0);
    chk("arst_out_data", qi.out_data, 0);
    resetn = 1'b1;
    cyc(1, 64'hD1, 0, 0);
    cyc(0, 0, 1, 0);
    chk("arst_next_count", qi.count, 1);
    chk("arst_next_data", qi.out_data, 64'hD1);
    cyc(0, 0, 0, 0);
    chk("arst_next_empty", qi.empty, 1);

    // Randomized traffic with occasional flush and reset pulses
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
          $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) begin
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
      end
    end

    cyc(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/stage_queue.md
STAGE_QUEUE -- requirements
Module: stage_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 64: payload width in bits, at least 1.
REQ-002 SHALL have parameter DEPTH, default 2: number of entries, a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all contents (branch or exception kill).
REQ-006 SHALL have port in_valid, input, 1 bit: upstream stage offers in_data.
REQ-007 SHALL have port in_allowin, output, 1 bit: queue accepts a push this cycle.
REQ-008 SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-009 SHALL have port out_valid, output, 1 bit: head entry is presented to the downstream stage.
REQ-010 SHALL have port out_allowin, input, 1 bit: downstream stage accepts the head entry.
REQ-011 SHALL have port out_data, output, WIDTH bits: head payload.
REQ-012 SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-013 SHALL have ports full and empty, outputs, 1 bit each: full is count==DEPTH; empty is count==0.

Function
REQ-014 SHALL implement a circular buffer of DEPTH entries with a read pointer and a write pointer, each $clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-015 SHALL drive in_allowin = !full, with no combinational dependence on out_allowin; this breaks the stage-to-stage allowin chain.
REQ-016 SHALL treat push = in_valid && in_allowin && !flush; a push writes in_data at the write pointer and advances the write pointer by 1.
REQ-017 SHALL drive out_valid = !empty && !flush.
REQ-018 SHALL treat pop = out_valid && out_allowin; a pop advances the read pointer by 1.
REQ-019 SHALL drive out_data = entry at the read pointer when out_valid is 1, and all zeros otherwise.
REQ-020 SHALL update count next edge as count + push - pop; count SHALL never exceed DEPTH or underflow.
REQ-021 SHALL, on push and pop in the same cycle, leave count unchanged and advance both pointers.
REQ-022 SHALL, when full, reject any push even if a pop occurs that cycle; the freed slot becomes available the following cycle.
REQ-023 SHALL have a minimum latency of 1 cycle: data pushed at edge N appears on out_data after edge N, with no combinational input-to-output bypass.
REQ-024 SHALL preserve order: entries leave in exactly the order accepted.
REQ-025 SHALL sustain a throughput of one entry per cycle when in_valid=1 and out_allowin=1 continuously.
REQ-026 SHALL, when flush=1, force out_valid=0 in that cycle, suppress push and pop, and at the next edge set both pointers and count to 0.
REQ-027 SHALL ignore in_data when no push occurs; stored entries SHALL be unchanged except by a push.

Reset
REQ-028 SHALL, while resetn=0 and independent of clk, hold both pointers at 0, count=0, empty=1, full=0, out_valid=0, in_allowin=1, out_data=0.
REQ-029 SHALL clear all storage entries to 0 on reset.
REQ-030 SHALL, on resetn falling mid-operation, discard all contents immediately, with no partial push or pop.
REQ-031 SHALL accept a push on the first rising edge after resetn deasserts, provided that edge sees resetn=1.

Verification (WIDTH=64, DEPTH=2)
REQ-032 Reset: assert resetn=0 -> out_valid=0, count=0, empty=1, in_allowin=1, out_data=0 before any clk edge.
REQ-033 Fill: push 0x1 then 0x2 with out_allowin=0 -> count=2, full=1, in_allowin=0, out_data=0x1; a third push of 0x3 is ignored.
REQ-034 Full with pop: full, in_valid=1 with 0x3, out_allowin=1 -> 0x1 popped, 0x3 not accepted; next cycle count=1, out_data=0x2, in_allowin=1.
REQ-035 Streaming: 8 consecutive pushes 0x10..0x17 with out_allowin=1 -> outputs 0x10..0x17 in order, one per cycle, 1-cycle latency, count steady at 1.
REQ-036 Flush: count=2 with in_valid=1 and flush=1 -> out_valid=0 in that cycle; next cycle count=0, empty=1, and the flushed-cycle input is never output.
REQ-037 Async reset mid-stream: resetn pulsed low between edges with count=1 -> count=0 and out_valid=0 immediately; the next push after release appears alone.
